// File: rtl/fir_scheduler.sv
// fir_scheduler -- sequences a FIR filter: start/compute/done handshakes,
// plus a coefficient-load window fed from a small write FIFO.
//
// Optional feature macro: FIR_SCHED_WATCHDOG_EN
//   defined   : COMPUTE is bounded by TIMEOUT_CYCLES; on expiry timeoutOut
//               sets (sticky) and the FSM returns to IDLE without doneOut.
//   undefined : no counter, timeoutOut tied 0, COMPUTE waits for firDoneIn.
//
// Ports
//   clkIn, resetIn  : clock (rising edge), async active-high reset
//   startReqIn      : pulse, sample packet received (start request)
//   loadModeIn      : level, coefficient load window requested
//   coefWrReqIn     : pulse, push coefDataIn into the coefficient FIFO
//   coefDataIn      : coefficient word (SAMPLES_NUM*IN_SAMPLE_WIDTH bits)
//   firDoneIn       : pulse from filter, computation finished
//   firStartOut     : pulse, start filter
//   firLoadOut      : level, filter in coefficient-load mode
//   firWriteOut     : pulse, coefficient write strobe
//   firCoefOut      : coefficient word, valid with firWriteOut
//   doneOut         : pulse, result ready
//   coefFullOut     : coefficient FIFO full
//   dropCountOut    : saturating count of rejected start requests
//   timeoutOut      : sticky watchdog flag
module fir_scheduler #(
  parameter int SAMPLES_NUM     = 8,
  parameter int IN_SAMPLE_WIDTH = 16,
  parameter int COEF_FIFO_DEPTH = 4,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                                   clkIn,
  input  logic                                   resetIn,
  input  logic                                   startReqIn,
  input  logic                                   loadModeIn,
  input  logic                                   coefWrReqIn,
  input  logic [SAMPLES_NUM*IN_SAMPLE_WIDTH-1:0] coefDataIn,
  input  logic                                   firDoneIn,
  output logic                                   firStartOut,
  output logic                                   firLoadOut,
  output logic                                   firWriteOut,
  output logic [SAMPLES_NUM*IN_SAMPLE_WIDTH-1:0] firCoefOut,
  output logic                                   doneOut,
  output logic                                   coefFullOut,
  output logic [7:0]                             dropCountOut,
  output logic                                   timeoutOut
);

  localparam int CW = SAMPLES_NUM * IN_SAMPLE_WIDTH;
  localparam int AW = $clog2(COEF_FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(COEF_FIFO_DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    COMPUTE = 3'd2,
    DONE    = 3'd3,
    COEF_WR = 3'd4
  } state_t;

  state_t state, state_n;
  logic   load_n;
  logic   pending;
  logic   accept, reject, enter_start;
  logic   wd_expire;

  // ---------------------------------------------------------------
  // Coefficient FIFO. Depth is a power of two, so the pointers wrap
  // by natural overflow; count is one bit wider to represent "full".
  // ---------------------------------------------------------------
  logic [CW-1:0] mem [COEF_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop, fifo_empty;

  assign coefFullOut = (count == FULL_CNT);
  assign fifo_empty  = (count == '0);
  assign push        = coefWrReqIn && !coefFullOut;
  // COEF_WR is only entered with a non-empty FIFO, so pop never underflows.
  assign pop         = (state == COEF_WR);

  always_ff @(posedge clkIn or posedge resetIn) begin
    if (resetIn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: emptiness is carried by the pointers/count.
  always_ff @(posedge clkIn) begin
    if (push) mem[wr_ptr] <= coefDataIn;
  end

  // ---------------------------------------------------------------
  // Start request admission. The "FSM busy while pending" rejection
  // case is a subset of "pending already set", so pending alone covers it.
  // ---------------------------------------------------------------
  assign accept      = startReqIn && !pending && !firLoadOut;
  assign reject      = startReqIn && !accept;
  assign enter_start = (state == IDLE) && (state_n == START);

  always_ff @(posedge clkIn or posedge resetIn) begin
    if (resetIn) begin
      pending <= 1'b0;
    end else if (enter_start) begin
      // An accepted request that starts immediately is consumed here too.
      pending <= 1'b0;
    end else if (accept) begin
      pending <= 1'b1;
    end
  end

  always_ff @(posedge clkIn or posedge resetIn) begin
    if (resetIn)
      dropCountOut <= 8'd0;
    else if (reject && dropCountOut != 8'hFF)
      dropCountOut <= dropCountOut + 8'd1;
  end

  // ---------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------
`ifdef FIR_SCHED_WATCHDOG_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);
  logic [WDW-1:0] wd_cnt;

  // wd_cnt holds (COMPUTE cycles elapsed - 1); it is cleared in every other
  // state, so each computation starts from zero.
  assign wd_expire = (state == COMPUTE) && (wd_cnt == WD_LAST) && !firDoneIn;

  always_ff @(posedge clkIn or posedge resetIn) begin
    if (resetIn) begin
      wd_cnt     <= '0;
      timeoutOut <= 1'b0;
    end else begin
      if (state == COMPUTE) wd_cnt <= wd_cnt + 1'b1;
      else                  wd_cnt <= '0;
      if (wd_expire) timeoutOut <= 1'b1;
    end
  end
`else
  assign wd_expire  = 1'b0;
  assign timeoutOut = 1'b0;
`endif

  // ---------------------------------------------------------------
  // Main FSM. firLoadOut is updated only from IDLE so a load request
  // never disturbs a computation in flight.
  // ---------------------------------------------------------------
  always_ff @(posedge clkIn or posedge resetIn) begin
    if (resetIn) begin
      state      <= IDLE;
      firLoadOut <= 1'b0;
    end else begin
      state      <= state_n;
      firLoadOut <= load_n;
    end
  end

  always_comb begin
    state_n = state;
    load_n  = firLoadOut;
    case (state)
      IDLE: begin
        if (firLoadOut) begin
          if (!fifo_empty)
            state_n = COEF_WR;
          // Leave load mode only when nothing is queued or arriving.
          else if (!loadModeIn && !coefWrReqIn)
            load_n = 1'b0;
        end else if (pending || accept) begin
          // A waiting start is served before opening a load window.
          state_n = START;
        end else if (loadModeIn) begin
          load_n = 1'b1;
        end
      end
      START:   state_n = COMPUTE;
      COMPUTE: begin
        if (firDoneIn)      state_n = DONE;
        else if (wd_expire) state_n = IDLE;
      end
      DONE:    state_n = IDLE;
      // Returning through IDLE spaces writes at least 2 cycles apart.
      COEF_WR: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign firStartOut = (state == START);
  assign doneOut     = (state == DONE);
  assign firWriteOut = (state == COEF_WR);
  assign firCoefOut  = firWriteOut ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_fir_scheduler.sv
// tb_fir_scheduler -- directed stimulus with a scoreboard. Stimulus pushes
// expected event cycles / coefficient words into queues; a negedge monitor
// pops and compares whenever the DUT raises firStartOut, doneOut or
// firWriteOut. Cycle N is the period following the Nth rising edge after
// reset release.
module tb_fir_scheduler;
  localparam int SN = 8, IW = 16, CW = SN*IW, DEPTH = 4, TO = 16;

  logic          clkIn = 1'b0, resetIn = 1'b1;
  logic          startReqIn = 1'b0, loadModeIn = 1'b0, coefWrReqIn = 1'b0, firDoneIn = 1'b0;
  logic [CW-1:0] coefDataIn = '0;
  logic          firStartOut, firLoadOut, firWriteOut, doneOut, coefFullOut, timeoutOut;
  logic [CW-1:0] firCoefOut;
  logic [7:0]    dropCountOut;

  fir_scheduler #(
    .SAMPLES_NUM(SN), .IN_SAMPLE_WIDTH(IW),
    .COEF_FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clkIn(clkIn), .resetIn(resetIn), .startReqIn(startReqIn),
    .loadModeIn(loadModeIn), .coefWrReqIn(coefWrReqIn), .coefDataIn(coefDataIn),
    .firDoneIn(firDoneIn), .firStartOut(firStartOut), .firLoadOut(firLoadOut),
    .firWriteOut(firWriteOut), .firCoefOut(firCoefOut), .doneOut(doneOut),
    .coefFullOut(coefFullOut), .dropCountOut(dropCountOut), .timeoutOut(timeoutOut)
  );

  always #5 clkIn = ~clkIn;

  int cyc;
  always @(posedge clkIn or posedge resetIn)
    if (resetIn) cyc <= 0;
    else         cyc <= cyc + 1;

  int            total = 0, passed = 0;
  int            exp_start_q[$], exp_done_q[$];
  logic [CW-1:0] exp_coef_q[$];
  logic [CW-1:0] words [7];
  int            last_wr = -100;
  int            mon_e;
  logic [CW-1:0] mon_w;

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor / scoreboard
  always @(negedge clkIn) begin
    if (!resetIn) begin
      if (firStartOut) begin
        if (exp_start_q.size() == 0) chk("unexpected firStartOut", 1, 0);
        else begin mon_e = exp_start_q.pop_front(); chk("firStartOut cycle", cyc, mon_e); end
      end
      if (doneOut) begin
        if (exp_done_q.size() == 0) chk("unexpected doneOut", 1, 0);
        else begin mon_e = exp_done_q.pop_front(); chk("doneOut cycle", cyc, mon_e); end
      end
      if (firWriteOut) begin
        if (exp_coef_q.size() == 0) chk("unexpected firWriteOut", 1, 0);
        else begin
          mon_w = exp_coef_q.pop_front();
          chk("firCoefOut data", firCoefOut, mon_w);
          chk("firWriteOut spacing", CW'(cyc - last_wr >= 2), 1);
          chk("firLoadOut during write", firLoadOut, 1);
        end
        last_wr = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clkIn); #1;
  endtask
  task automatic ticks(input int n);
    repeat (n) tick();
  endtask
  task automatic wait_cyc(input int c);
    for (int i = 0; i < 1000 && cyc < c; i++) tick();
    chk("reached cycle", cyc, c);
  endtask
  task automatic start_pulse();
    startReqIn = 1'b1; tick(); startReqIn = 1'b0;
  endtask
  task automatic done_pulse();
    firDoneIn = 1'b1; tick(); firDoneIn = 1'b0;
  endtask
  task automatic chk_all_zero(input string tag);
    chk({tag, " firStartOut"},  firStartOut, 0);
    chk({tag, " firLoadOut"},   firLoadOut, 0);
    chk({tag, " firWriteOut"},  firWriteOut, 0);
    chk({tag, " firCoefOut"},   firCoefOut, 0);
    chk({tag, " doneOut"},      doneOut, 0);
    chk({tag, " coefFullOut"},  coefFullOut, 0);
    chk({tag, " dropCountOut"}, dropCountOut, 0);
    chk({tag, " timeoutOut"},   timeoutOut, 0);
  endtask

  initial begin
    int t;
    for (int i = 0; i < 7; i++)
      words[i] = {8{16'hC000 + 16'(i * 16'h0111)}};

    // Reset state
    #12;
    chk_all_zero("reset");
    #1 resetIn = 1'b0;

    // Single start at cycle 10, done at cycle 40
    wait_cyc(10);
    exp_start_q.push_back(11);
    start_pulse();
    wait_cyc(40);
    exp_done_q.push_back(41);
    done_pulse();
    ticks(3);
    chk("dropCount single", dropCountOut, 0);

    // Three starts during one COMPUTE: one queued, two dropped
    t = cyc;
    exp_start_q.push_back(t + 1);
    start_pulse();
    ticks(2);
    start_pulse(); tick();
    start_pulse(); tick();
    start_pulse();
    t = cyc;
    exp_done_q.push_back(t + 1);
    exp_start_q.push_back(t + 3);
    done_pulse();
    ticks(3);
    // Start coinciding with done is accepted
    t = cyc;
    exp_done_q.push_back(t + 1);
    exp_start_q.push_back(t + 3);
    startReqIn = 1'b1; firDoneIn = 1'b1; tick();
    startReqIn = 1'b0; firDoneIn = 1'b0;
    ticks(3);
    exp_done_q.push_back(cyc + 1);
    done_pulse();
    ticks(2);
    chk("dropCount after 3 starts", dropCountOut, 2);

    // Load request and 5 pushes during COMPUTE (depth 4)
    t = cyc;
    exp_start_q.push_back(t + 1);
    start_pulse();
    tick();
    loadModeIn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      coefWrReqIn = 1'b1; coefDataIn = words[i];
      if (i < 4) exp_coef_q.push_back(words[i]);
      tick();
    end
    coefWrReqIn = 1'b0;
    chk("coefFullOut after 4+1 pushes", coefFullOut, 1);
    chk("firLoadOut held during COMPUTE", firLoadOut, 0);
    exp_done_q.push_back(cyc + 1);
    done_pulse();
    for (int i = 0; i < 60 && exp_coef_q.size() != 0; i++) tick();
    chk("coef queue drained", exp_coef_q.size(), 0);
    tick();
    chk("coefFullOut after drain", coefFullOut, 0);
    chk("firLoadOut in load window", firLoadOut, 1);
    start_pulse();
    tick();
    chk("dropCount start during load", dropCountOut, 3);

    // Drop loadModeIn with 2 words queued: drain first, then leave load
    loadModeIn = 1'b0;
    coefWrReqIn = 1'b1; coefDataIn = words[5]; exp_coef_q.push_back(words[5]); tick();
    coefDataIn = words[6]; exp_coef_q.push_back(words[6]); tick();
    coefWrReqIn = 1'b0;
    chk("firLoadOut held while draining", firLoadOut, 1);
    for (int i = 0; i < 40 && exp_coef_q.size() != 0; i++) tick();
    chk("coef queue drained 2", exp_coef_q.size(), 0);
    ticks(2);
    chk("firLoadOut fell", firLoadOut, 0);
    exp_start_q.push_back(cyc + 1);
    start_pulse();
    tick();
    exp_done_q.push_back(cyc + 1);
    done_pulse();
    ticks(2);
    chk("dropCount unchanged", dropCountOut, 3);

    // Watchdog
`ifdef FIR_SCHED_WATCHDOG_EN
    t = cyc;
    exp_start_q.push_back(t + 1);
    start_pulse();
    ticks(16);
    chk("timeoutOut before expiry", timeoutOut, 0);
    tick();
    chk("timeoutOut at expiry", timeoutOut, 1);
    exp_start_q.push_back(cyc + 1);
    start_pulse();
    tick();
    exp_done_q.push_back(cyc + 1);
    done_pulse();
    ticks(2);
    chk("timeoutOut sticky", timeoutOut, 1);
`else
    exp_start_q.push_back(cyc + 1);
    start_pulse();
    ticks(40);
    chk("timeoutOut disabled", timeoutOut, 0);
    exp_done_q.push_back(cyc + 1);
    done_pulse();
    ticks(2);
    chk("timeoutOut disabled after done", timeoutOut, 0);
`endif

    // Reset mid-COMPUTE with 2 FIFO entries
    exp_start_q.push_back(cyc + 1);
    start_pulse();
    tick();
    coefWrReqIn = 1'b1; coefDataIn = words[0]; tick();
    coefDataIn = words[1]; tick();
    coefWrReqIn = 1'b0;
    ticks(2);
    #2 resetIn = 1'b1;
    #1 chk_all_zero("async reset");
    #10 resetIn = 1'b0;
    loadModeIn = 1'b1;
    ticks(20);
    chk("firLoadOut after reset", firLoadOut, 1);
    chk("coefFullOut after reset", coefFullOut, 0);
    loadModeIn = 1'b0;
    ticks(4);

    chk("pending firStartOut events", exp_start_q.size(), 0);
    chk("pending doneOut events", exp_done_q.size(), 0);
    chk("pending firWriteOut words", exp_coef_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fir_scheduler.md
FIR_SCHEDULER -- requirements
Module: fir_scheduler

Interface
REQ-001 The block SHALL have parameter SAMPLES_NUM, default 8, which sets the samples per packet (1..8).
REQ-002 The block SHALL have parameter IN_SAMPLE_WIDTH, default 16, which sets the coefficient word width.
REQ-003 The block SHALL have parameter COEF_FIFO_DEPTH, default 4, which sets the coefficient-write FIFO depth (power of 2, at least 2).
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 1024, which sets the compute watchdog limit.
REQ-005 The block SHALL have one clock and an asynchronous active-high reset, with the following ports:
- clkIn  in  1  sole clock, rising edge.
- resetIn  in  1  asynchronous, active-high reset.
- startReqIn  in  1  one-cycle pulse: sample packet received.
- loadModeIn  in  1  level: coefficient load window requested.
- coefWrReqIn  in  1  one-cycle pulse: coefficient word ready.
- coefDataIn  in  SAMPLES_NUM*IN_SAMPLE_WIDTH  coefficient word, valid with coefWrReqIn.
- firDoneIn  in  1  one-cycle pulse from filter: computation finished.
- firStartOut  out  1  one-cycle start pulse to filter.
- firLoadOut  out  1  level: filter in coefficient-load mode.
- firWriteOut  out  1  one-cycle coefficient write strobe.
- firCoefOut  out  SAMPLES_NUM*IN_SAMPLE_WIDTH  coefficient word, valid with firWriteOut.
- doneOut  out  1  one-cycle pulse: result ready to latch.
- coefFullOut  out  1  coefficient FIFO full.
- dropCountOut  out  8  count of rejected start requests.
- timeoutOut  out  1  sticky watchdog flag.

Function
REQ-006 The FSM SHALL have states IDLE, START, COMPUTE, DONE and COEF_WR, all of which are one cycle long except COMPUTE.
REQ-007 A one-deep pending-start flag SHALL be set by a startReqIn that is accepted, and cleared on entering START.
REQ-008 startReqIn SHALL be rejected when the pending flag is already set, when FSM is not IDLE while pending is set, or when firLoadOut is high. Each rejection SHALL increment dropCountOut, saturating at 255.
REQ-009 A startReqIn coinciding with firDoneIn SHALL be accepted, because pending is empty at that point.
REQ-010 From IDLE, with pending set and firLoadOut low, the FSM SHALL enter START, so that firStartOut is high for the cycle after the startReqIn edge.
REQ-011 START SHALL transition to COMPUTE, and COMPUTE SHALL exit to DONE on firDoneIn.
REQ-012 doneOut SHALL be high for exactly one cycle in DONE, after which the FSM returns to IDLE.
REQ-013 firDoneIn SHALL be ignored outside COMPUTE.
REQ-014 Each coefWrReqIn SHALL push coefDataIn into the FIFO. A push when the FIFO is full SHALL be dropped with the FIFO contents unchanged.
REQ-015 coefFullOut SHALL be high exactly when the FIFO count equals COEF_FIFO_DEPTH.
REQ-016 A simultaneous push and pop SHALL leave the FIFO count unchanged, and the FIFO pointers SHALL wrap modulo COEF_FIFO_DEPTH.
REQ-017 firLoadOut SHALL change only in IDLE.
REQ-018 In IDLE, firLoadOut SHALL rise when loadModeIn is high, and SHALL fall only when loadModeIn is low and the FIFO is empty, so that queued coefficients are drained first.
REQ-019 From IDLE, with firLoadOut high and the FIFO non-empty, the FSM SHALL enter COEF_WR. In COEF_WR, firWriteOut SHALL be 1 and firCoefOut SHALL carry the FIFO head, which is popped.
REQ-020 Back-to-back coefficient writes SHALL be at least 2 cycles apart.
REQ-021 IDLE priority SHALL be: COEF_WR when firLoadOut is high, otherwise START.
REQ-022 A rising loadModeIn while the FSM is not IDLE SHALL take effect only after the FSM returns to IDLE, and SHALL never abort a computation.

Reset
REQ-023 On resetIn, asynchronously, the FSM SHALL go to IDLE, the pending flag and FIFO SHALL be emptied, and dropCountOut and timeoutOut SHALL be cleared to 0.
REQ-024 On resetIn, all outputs SHALL be 0; coefFullOut is 0 because the FIFO is empty.
REQ-025 Reset asserted in COMPUTE or COEF_WR SHALL abandon the operation with no doneOut or firWriteOut emitted after reset.
REQ-026 The first accepted action SHALL occur on the first clkIn edge after resetIn falls.

Configuration
REQ-027 With the macro FIR_SCHED_WATCHDOG_EN defined, a cycle counter SHALL run in COMPUTE. Reaching TIMEOUT_CYCLES without firDoneIn SHALL set timeoutOut (sticky until reset) and return the FSM to IDLE without doneOut.
REQ-028 Without FIR_SCHED_WATCHDOG_EN, no counter SHALL be built, timeoutOut SHALL be tied 0, and COMPUTE SHALL wait indefinitely.

Verification
REQ-029 Bench SHALL cover: startReqIn at cycle 10, firDoneIn at cycle 40 -> firStartOut at cycle 11 only, doneOut at cycle 41 only, dropCountOut = 0.
REQ-030 Bench SHALL cover: three startReqIn pulses during one COMPUTE -> first queued, next two dropped, dropCountOut = 2, and a second firStartOut issued after DONE.
REQ-031 Bench SHALL cover: loadModeIn high, 5 coefWrReqIn pushes back-to-back with depth 4 -> coefFullOut high after 4, fifth word lost, four firWriteOut pulses ≥2 cycles apart in push order.
REQ-032 Bench SHALL cover: loadModeIn dropped with 2 words queued -> firLoadOut stays 1 until the second firWriteOut, then falls, and a following startReqIn is accepted.
REQ-033 Bench SHALL cover: with FIR_SCHED_WATCHDOG_EN, TIMEOUT_CYCLES = 16 and no firDoneIn -> timeoutOut = 1 after 16 COMPUTE cycles, no doneOut, FSM IDLE, and a new start accepted.
REQ-034 Bench SHALL cover: resetIn pulsed mid-COMPUTE with 2 FIFO entries -> all outputs 0 immediately, and no firWriteOut or doneOut after release.
